// File: rtl/dense_layer_mac.sv
// Sequential MAC engine for one fully-connected layer: bias + sum(in*w),
// arithmetic-shift requantization, optional ReLU, saturation to OUT_WIDTH.
module dense_layer_mac #(
  parameter int unsigned IN_WIDTH  = 8,
  parameter int unsigned W_WIDTH   = 8,
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned OUT_WIDTH = 8,
  parameter int unsigned NUM_IN    = 16,
  parameter int unsigned NUM_OUT   = 8,
  parameter int unsigned SHIFT     = 4,
  parameter int unsigned RELU_EN   = 1
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start,
  input  logic [NUM_IN*IN_WIDTH-1:0]                  in_vec,
  output logic                                        busy,
  input  logic                                        w_valid,
  output logic                                        w_ready,
  input  logic [W_WIDTH-1:0]                          w_data,
  input  logic [ACC_WIDTH-1:0]                        b_data,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [OUT_WIDTH-1:0]                        out_data,
  output logic [((NUM_OUT > 1) ? $clog2(NUM_OUT) : 1)-1:0] out_idx,
  output logic                                        out_last,
  output logic                                        done
);

  localparam int unsigned K_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int unsigned N_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam int unsigned P_W = IN_WIDTH + W_WIDTH;
  localparam logic [K_W-1:0] K_LAST = K_W'(NUM_IN - 1);
  localparam logic [N_W-1:0] N_LAST = N_W'(NUM_OUT - 1);
  localparam logic signed [ACC_WIDTH-1:0] OUT_MAX = ACC_WIDTH'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [ACC_WIDTH-1:0] OUT_MIN = ~OUT_MAX;

  typedef enum logic [2:0] {S_IDLE, S_MAC, S_RES, S_OUT, S_DONE} state_t;

  state_t                       state_q, state_d;
  logic [NUM_IN*IN_WIDTH-1:0]   in_q, in_d;
  logic [K_W-1:0]               k_q, k_d;
  logic [N_W-1:0]               n_q, n_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [OUT_WIDTH-1:0]         out_data_q, out_data_d;
  logic [N_W-1:0]               out_idx_q, out_idx_d;
  logic                         out_last_q, out_last_d;
  logic                         busy_q, busy_d;
  logic                         w_ready_q, w_ready_d;
  logic                         out_valid_q, out_valid_d;
  logic                         done_q, done_d;

  logic signed [IN_WIDTH-1:0]   in_k;
  logic signed [W_WIDTH-1:0]    w_s;
  logic signed [P_W-1:0]        prod;
  logic signed [ACC_WIDTH-1:0]  acc_sum;
  logic signed [ACC_WIDTH-1:0]  res;

  always_comb begin
    state_d    = state_q;
    in_d       = in_q;
    k_d        = k_q;
    n_d        = n_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    out_idx_d  = out_idx_q;
    out_last_d = out_last_q;

    // Full-width signed product, sign-extended into the wrapping accumulator
    in_k    = in_q[int'(k_q)*IN_WIDTH +: IN_WIDTH];
    w_s     = w_data;
    prod    = P_W'(in_k) * P_W'(w_s);
    acc_sum = ((k_q == '0) ? $signed(b_data) : acc_q) + ACC_WIDTH'(prod);

    // Requantize: floor shift, optional ReLU, then clamp to output range
    res = acc_q >>> SHIFT;
    if ((RELU_EN != 0) && (res < 0)) res = '0;
    if (res > OUT_MAX)      res = OUT_MAX;
    else if (res < OUT_MIN) res = OUT_MIN;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          in_d    = in_vec;
          n_d     = '0;
          k_d     = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        if (w_valid) begin
          acc_d = acc_sum;
          if (k_q == K_LAST) state_d = S_RES;
          else               k_d = k_q + K_W'(1);
        end
      end
      S_RES: begin
        out_data_d = OUT_WIDTH'(res);
        out_idx_d  = n_q;
        out_last_d = (n_q == N_LAST);
        state_d    = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          if (n_q == N_LAST) begin
            state_d = S_DONE;
          end else begin
            n_d     = n_q + N_W'(1);
            k_d     = '0;
            state_d = S_MAC;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered from the next state
    busy_d      = (state_d != S_IDLE);
    w_ready_d   = (state_d == S_MAC);
    out_valid_d = (state_d == S_OUT);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_q        <= '0;
      k_q         <= '0;
      n_q         <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      w_ready_q   <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_q        <= in_d;
      k_q         <= k_d;
      n_q         <= n_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      w_ready_q   <= w_ready_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  assign busy      = busy_q;
  assign w_ready   = w_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign done      = done_q;

endmodule

// File: tb/tb_dense_layer_mac.sv
// Scoreboard bench for dense_layer_mac: two instances (ReLU on / off) share
// one stimulus stream; expected neuron results are queued as weights are fed.
module tb_dense_layer_mac;

  localparam int NI = 16;
  localparam int NO = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic [NI*8-1:0] in_vec = '0;
  logic            w_valid = 1'b0;
  logic [7:0]      w_data = '0;
  logic [31:0]     b_data = '0;
  logic            out_ready = 1'b0;

  logic       busy_r, w_ready_r, out_valid_r, out_last_r, done_r;
  logic [7:0] out_data_r;
  logic [2:0] out_idx_r;
  logic       busy_n, w_ready_n, out_valid_n, out_last_n, done_n;
  logic [7:0] out_data_n;
  logic [2:0] out_idx_n;

  dense_layer_mac #(.RELU_EN(1)) dut_r (
    .clk(clk), .rst(rst), .start(start), .in_vec(in_vec), .busy(busy_r),
    .w_valid(w_valid), .w_ready(w_ready_r), .w_data(w_data), .b_data(b_data),
    .out_valid(out_valid_r), .out_ready(out_ready), .out_data(out_data_r),
    .out_idx(out_idx_r), .out_last(out_last_r), .done(done_r));

  dense_layer_mac #(.RELU_EN(0)) dut_n (
    .clk(clk), .rst(rst), .start(start), .in_vec(in_vec), .busy(busy_n),
    .w_valid(w_valid), .w_ready(w_ready_n), .w_data(w_data), .b_data(b_data),
    .out_valid(out_valid_n), .out_ready(out_ready), .out_data(out_data_n),
    .out_idx(out_idx_n), .out_last(out_last_n), .done(done_n));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d_r;
    logic [7:0] d_n;
    logic [2:0] idx;
    logic       last;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   in_mem[NI];
  int   w_mem[NO][NI];
  int   b_mem[NO];

  function automatic logic [7:0] requant(input int acc, input bit relu);
    int r;
    r = acc >>> 4;
    if (relu && r < 0) r = 0;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return r[7:0];
  endfunction

  function automatic exp_t expect_neuron(input int n);
    exp_t e;
    int   acc;
    acc = b_mem[n];
    for (int k = 0; k < NI; k++) acc += in_mem[k] * w_mem[n][k];
    e.d_r  = requant(acc, 1'b1);
    e.d_n  = requant(acc, 1'b0);
    e.idx  = n[2:0];
    e.last = (n == NO - 1);
    return e;
  endfunction

  task automatic fill_const(input int iv, input int wv, input int bv);
    for (int k = 0; k < NI; k++) in_mem[k] = iv;
    for (int n = 0; n < NO; n++) begin
      b_mem[n] = bv;
      for (int k = 0; k < NI; k++) w_mem[n][k] = wv;
    end
  endtask

  task automatic fill_random();
    for (int k = 0; k < NI; k++) in_mem[k] = $urandom_range(0, 255) - 128;
    for (int n = 0; n < NO; n++) begin
      b_mem[n] = $urandom;
      for (int k = 0; k < NI; k++) w_mem[n][k] = $urandom_range(0, 255) - 128;
    end
  endtask

  // Drives one layer; abort_n >= 0 resets the DUTs mid-MAC of that neuron
  task automatic run_layer(input bit rand_wv, input int stall_idx, input bit pulse_start,
                           input int abort_n, output int done_cyc, output int done_cnt);
    int         cyc, wn, wk, stall_cnt;
    bit         fin, aborted;
    logic [7:0] stall_data;
    exp_t       e;
    sb.delete();
    @(negedge clk);
    for (int k = 0; k < NI; k++) in_vec[k*8 +: 8] = 8'(in_mem[k]);
    start = 1'b1; w_valid = 1'b0; out_ready = 1'b0;
    wn = 0; wk = 0; stall_cnt = 0; done_cyc = -1; done_cnt = 0; fin = 0; aborted = 0;
    stall_data = '0;
    @(negedge clk);
    start = 1'b0;
    in_vec = {$urandom, $urandom, $urandom, $urandom};
    cyc = 1;
    while (!fin && cyc < 3000) begin
      checks++;
      if (out_valid_n !== out_valid_r || w_ready_n !== w_ready_r || done_n !== done_r) begin
        failures++;
        $display("FAIL lockstep cyc=%0d r(v,rdy,done)=%b%b%b n=%b%b%b", cyc,
                 out_valid_r, w_ready_r, done_r, out_valid_n, w_ready_n, done_n);
      end
      checks++;
      if (out_valid_r === 1'b1 && w_ready_r !== 1'b0) begin
        failures++;
        $display("FAIL w_ready_in_out cyc=%0d got=%b want=0", cyc, w_ready_r);
      end
      if (done_r === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        checks++;
        if (busy_r !== 1'b0 || busy_n !== 1'b0 || done_r !== 1'b0) begin
          failures++;
          $display("FAIL busy_after_done got busy=%b%b done=%b want=000", busy_r, busy_n, done_r);
        end
        fin = 1;
      end else if (abort_n >= 0 && wn == abort_n && wk == 5) begin
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy_r, w_ready_r, out_valid_r, out_data_r, out_idx_r, out_last_r, done_r} !== 16'h0 ||
            {busy_n, w_ready_n, out_valid_n, out_data_n, out_idx_n, out_last_n, done_n} !== 16'h0) begin
          failures++;
          $display("FAIL reset_mid_outputs got r=%h n=%h want=0",
                   {busy_r, w_ready_r, out_valid_r, out_data_r, out_idx_r, out_last_r, done_r},
                   {busy_n, w_ready_n, out_valid_n, out_data_n, out_idx_n, out_last_n, done_n});
        end
        w_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        fin = 1; aborted = 1;
      end else begin
        start  = (pulse_start && cyc == 40);
        w_valid = rand_wv ? 1'($urandom_range(0, 1)) : 1'b1;
        w_data  = 8'($urandom);
        b_data  = $urandom;
        if (wn < NO) begin
          w_data = w_mem[wn][wk][7:0];
          if (wk == 0) b_data = b_mem[wn];
        end
        if (w_valid && w_ready_r === 1'b1) begin
          if (wn >= NO) begin
            failures++;
            $display("FAIL extra_weight cyc=%0d got=consumed want=idle", cyc);
          end else begin
            wk++;
            if (wk == NI) begin
              sb.push_back(expect_neuron(wn));
              wk = 0;
              wn++;
            end
          end
        end
        out_ready = 1'b1;
        if (out_valid_r === 1'b1 && int'(out_idx_r) == stall_idx && stall_cnt < 5) begin
          if (stall_cnt == 0) stall_data = out_data_n;
          else begin
            checks++;
            if (out_data_n !== stall_data || int'(out_idx_r) != stall_idx) begin
              failures++;
              $display("FAIL stall_stable got data=%h idx=%0d want data=%h idx=%0d",
                       out_data_n, out_idx_r, stall_data, stall_idx);
            end
          end
          out_ready = 1'b0;
          stall_cnt++;
        end
        if (out_valid_r === 1'b1 && out_ready) begin
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_out got idx=%0d want=none", out_idx_r);
          end else begin
            e = sb.pop_front();
            if (out_data_r !== e.d_r || out_data_n !== e.d_n || out_idx_r !== e.idx ||
                out_idx_n !== e.idx || out_last_r !== e.last || out_last_n !== e.last) begin
              failures++;
              $display("FAIL out_result got r=%h n=%h idx=%0d last=%b want r=%h n=%h idx=%0d last=%b",
                       out_data_r, out_data_n, out_idx_r, out_last_r, e.d_r, e.d_n, e.idx, e.last);
            end
          end
        end
        @(negedge clk);
        cyc++;
      end
    end
    w_valid = 1'b0; out_ready = 1'b0; start = 1'b0;
    checks++;
    if (!fin) begin
      failures++;
      $display("FAIL layer_timeout got cyc=%0d want done", cyc);
    end else if (!aborted && (sb.size() != 0 || wn != NO)) begin
      failures++;
      $display("FAIL layer_complete got pending=%0d neurons_fed=%0d want 0/%0d", sb.size(), wn, NO);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy_r, w_ready_r, out_valid_r, out_data_r, out_idx_r, out_last_r, done_r} !== 16'h0 ||
        {busy_n, w_ready_n, out_valid_n, out_data_n, out_idx_n, out_last_n, done_n} !== 16'h0) begin
      failures++;
      $display("FAIL reset_outputs got r=%h n=%h want=0",
               {busy_r, w_ready_r, out_valid_r, out_data_r, out_idx_r, out_last_r, done_r},
               {busy_n, w_ready_n, out_valid_n, out_data_n, out_idx_n, out_last_n, done_n});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy_r !== 1'b0 || busy_n !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_busy got=%b%b want=00", busy_r, busy_n);
    end
  endtask

  task automatic test_basic();
    int dc, dn;
    fill_const(2, 3, 4);
    run_layer(1'b0, -1, 1'b0, -1, dc, dn);
    checks++;
    if (dc != 145 || dn != 1) begin
      failures++;
      $display("FAIL basic_done_cycle got cyc=%0d pulses=%0d want cyc=145 pulses=1", dc, dn);
    end
  endtask

  task automatic test_relu();
    int dc, dn;
    fill_const(1, 1, -100);
    run_layer(1'b0, -1, 1'b0, -1, dc, dn);
  endtask

  task automatic test_saturation();
    int dc, dn;
    fill_const(127, 127, 0);
    run_layer(1'b0, -1, 1'b0, -1, dc, dn);
    fill_const(127, -127, 0);
    run_layer(1'b0, -1, 1'b0, -1, dc, dn);
  endtask

  task automatic test_backpressure();
    int dc, dn;
    fill_random();
    run_layer(1'b1, 3, 1'b1, -1, dc, dn);
    checks++;
    if (dn != 1) begin
      failures++;
      $display("FAIL backpressure_done got pulses=%0d want=1", dn);
    end
  endtask

  task automatic test_reset_mid();
    int dc, dn;
    fill_const(2, 3, 4);
    run_layer(1'b0, -1, 1'b0, 2, dc, dn);
    checks++;
    if (dn != 0) begin
      failures++;
      $display("FAIL reset_mid_no_done got pulses=%0d want=0", dn);
    end
    run_layer(1'b0, -1, 1'b0, -1, dc, dn);
    checks++;
    if (dc != 145 || dn != 1) begin
      failures++;
      $display("FAIL reset_mid_restart got cyc=%0d pulses=%0d want cyc=145 pulses=1", dc, dn);
    end
  endtask

  task automatic test_random();
    int dc, dn;
    for (int i = 0; i < 3; i++) begin
      fill_random();
      run_layer(1'b1, -1, 1'b0, -1, dc, dn);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_relu();
    test_saturation();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dense_layer_mac.md
# dense_layer_mac

Sequential multiply-accumulate engine that evaluates one fully-connected MLP layer: out[n] = requant(bias[n] + Σ in[k]·w[n][k]), optionally followed by ReLU. It sits directly under the MLP layer-sequencing FSM. The FSM drives `start` with the layer input vector, the weight fetcher streams weights and biases into it, and the neuron results stream back out one per handshake to be written as the next layer's input.

## Interface
- IN_WIDTH, 8: signed activation width.
- W_WIDTH, 8: signed weight width.
- ACC_WIDTH, 32: signed accumulator and bias width.
- OUT_WIDTH, 8: signed output width.
- NUM_IN, 16: inputs per neuron (≥2).
- NUM_OUT, 8: neurons per layer (≥1).
- SHIFT, 4: arithmetic right shift applied at requantization.
- RELU_EN, 1: 1 clamps negative results to 0.

Ports:
- clk  in  1  clock. One clock domain; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request. Sampled only in IDLE.
- in_vec  in  NUM_IN*IN_WIDTH  input vector; element k is at bits [k*IN_WIDTH +: IN_WIDTH]. Captured on accepted start.
- busy  out  1  high whenever the state is not IDLE.
- w_valid  in  1  weight word valid.
- w_ready  out  1  high only in MAC.
- w_data  in  W_WIDTH  weight w[n][k], streamed with k ascending, then n ascending.
- b_data  in  ACC_WIDTH  bias[n]. Sampled on the accepted k==0 weight of neuron n.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_data  out  OUT_WIDTH  requantized result.
- out_idx  out  max(1,$clog2(NUM_OUT))  neuron index n.
- out_last  out  1  high with out_valid when n==NUM_OUT-1.
- done  out  1  one-cycle pulse after the last result handshake.

## Operation
States: IDLE, MAC, RES, OUT, DONE.

- **IDLE**
  - start=1: latch in_vec, set n=0, k=0, go to MAC.
  - start is ignored in every other state.
- **MAC**
  - Weight handshake when w_valid&&w_ready.
  - On each handshake: acc ← (k==0 ? b_data : acc) + sext(in[k])·sext(w_data).
  - Products are full signed IN_WIDTH+W_WIDTH width, sign-extended to ACC_WIDTH.
  - The accumulator wraps modulo 2^ACC_WIDTH; there is no accumulator saturation.
  - On the handshake with k==NUM_IN-1, go to RES; otherwise k++.
  - With no handshake, state, acc and k hold.
- **RES** (1 cycle)
  - r = acc >>> SHIFT (arithmetic shift, floor).
  - If RELU_EN and r<0, then r=0.
  - Saturate r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - Register r to out_data, n to out_idx, (n==NUM_OUT-1) to out_last.
  - Go to OUT.
- **OUT**
  - out_valid=1. out_data, out_idx and out_last are stable until the handshake.
  - On out_ready: if n==NUM_OUT-1, go to DONE; else n++, k=0, go to MAC.
- **DONE**
  - done=1 for exactly one cycle, then go to IDLE.
- **Reset** (any time, including mid-layer)
  - State returns to IDLE; acc, k and n clear.
  - Any partial layer is discarded; no done is issued for it.
  - All outputs are 0.

## Timing
- Reset value of every output is 0: busy, w_ready, out_valid, out_data, out_idx, out_last, done.
- Cycle numbering, with start accepted at cycle 0:
  - busy=1 and w_ready=1 from cycle 1.
  - With w_valid held at 1, weights are accepted in cycles 1..NUM_IN.
  - RES occupies cycle NUM_IN+1.
  - out_valid=1 in cycle NUM_IN+2.
- Per-neuron minimum is NUM_IN+2 cycles.
- Layer minimum: done in cycle NUM_OUT·(NUM_IN+2)+1; busy falls the cycle after.
- w_ready is 0 in RES, OUT and DONE. A w_valid asserted in those states is not consumed.
- out_valid rises only in OUT and drops the cycle after the out handshake.
- A new start is accepted no earlier than the cycle after DONE, i.e. in IDLE.

## Test plan
- **Reset values:** assert rst asynchronously mid-cycle → all outputs 0 immediately; busy=0 after release.
- **Basic layer (defaults):** in=2 (all), w=3 (all), bias=4, w_valid=1, out_ready=1.
  - acc=100, so out_data=6 for idx 0..7; out_last only on idx 7.
  - done at cycle 145 after start.
- **ReLU:** in=1, w=1, bias=-100, giving acc=-84.
  - RELU_EN=1 → out_data=0.
  - RELU_EN=0 → out_data=-6 (0xFA).
- **Saturation:** in=127, w=127, bias=0, giving acc=258064 and shifted 16129.
  - out_data=127 for every neuron.
  - Negating the weights to -127 → -128 with RELU_EN=0, and 0 with RELU_EN=1.
- **Backpressure:**
  - Toggle w_valid randomly and hold out_ready=0 for 5 cycles on idx 3 → out_data/out_idx stable, no weights consumed during the stall, results unchanged.
  - Pulse start while busy → ignored.
- **Reset mid-layer:** assert rst during MAC of neuron 2, then restart with the basic-layer stimulus → full correct layer from idx 0, exactly one done pulse.
